// File: rtl/keccak_padder_param.sv
// keccak_padder_param: pad10*1 Keccak padder that packs W-bit message words into RATE-bit blocks
//
// Parameters:
//   W      input word width in bits, a multiple of 8 and at least 16
//   RATE   block width in bits, a multiple of W
//   DSBYTE domain-separation byte (Keccak 8'h01, SHA-3 8'h06, SHAKE 8'h1F)
//
// Ports:
//   clk_i         clock
//   reset_i       asynchronous active-high reset
//   in_i          message word; the first byte is in_i[W-1:W-8]
//   in_valid_i    a word is presented
//   is_last_i     the presented word is the message tail
//   byte_num_i    number of valid bytes in the tail word, counted from the MSB end
//   in_ready_o    the word is taken when in_valid_i & in_ready_o
//   out_o         padded block; the first word is in out_o[RATE-1:RATE-W]
//   out_valid_o   out_o holds a complete block
//   out_ack_i     the consumer took the block
//
// Optional feature, enabled by defining KECCAK_PADDER_LAST_EN:
//   out_last_o    high with out_valid_o when the block is the final block of the message
//   blk_cnt_o     number of blocks acked for the current message, cleared on the final ack
module keccak_padder_param #(
    parameter int         W      = 32,
    parameter int         RATE   = 1088,
    parameter logic [7:0] DSBYTE = 8'h06
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [W-1:0]              in_i,
    input  logic                      in_valid_i,
    input  logic                      is_last_i,
    input  logic [$clog2(W/8)-1:0]    byte_num_i,
    output logic                      in_ready_o,
    output logic [RATE-1:0]           out_o,
    output logic                      out_valid_o,
`ifdef KECCAK_PADDER_LAST_EN
    output logic                      out_last_o,
    output logic [15:0]               blk_cnt_o,
`endif
    input  logic                      out_ack_i
);

    localparam int WORDS = RATE / W;
    localparam int CW    = $clog2(WORDS + 1);
    localparam int NB    = W / 8;

    typedef enum logic {FILL, PAD} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [RATE-1:0] out_q;
    logic            out_valid_q;

    logic            accept;
    logic            pad_ins;
    logic            ins;
    logic            completes;
    logic            fin;
    logic [W-1:0]    tail_word;
    logic [W-1:0]    ins_word;

    assign in_ready_o  = (state_q == FILL) & ~out_valid_q;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;

    assign accept    = in_valid_i & in_ready_o;
    assign pad_ins   = (state_q == PAD) & ~out_valid_q & (cnt_q != CW'(WORDS));
    assign ins       = accept | pad_ins;
    assign completes = ins & (cnt_q == CW'(WORDS - 1));
    // Only a block holding (or following) the tail gets the closing 0x80.
    assign fin       = completes & (pad_ins | is_last_i);

    // Tail word: kept message bytes, DSBYTE right after them, zeros beyond.
    always_comb begin
        tail_word = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < int'(byte_num_i))
                tail_word[W-1-8*b -: 8] = in_i[W-1-8*b -: 8];
            else if (b == int'(byte_num_i))
                tail_word[W-1-8*b -: 8] = DSBYTE;
        end
    end

    assign ins_word = (accept & ~is_last_i ? in_i : accept ? tail_word : '0)
                    | {{(W-8){1'b0}}, fin ? 8'h80 : 8'h00};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (out_valid_q) begin
            if (out_ack_i) begin
                out_valid_q <= 1'b0;
                cnt_q       <= '0;
                // Any block completed in PAD carries the tail, so it closes the message.
                if (state_q == PAD)
                    state_q <= FILL;
            end
        end else if (ins) begin
            out_q <= (out_q << W) | RATE'(ins_word);
            cnt_q <= cnt_q + CW'(1);
            if (completes)
                out_valid_q <= 1'b1;
            if (accept & is_last_i)
                state_q <= PAD;
        end
    end

`ifdef KECCAK_PADDER_LAST_EN
    logic        out_last_q;
    logic [15:0] blk_cnt_q;

    assign out_last_o = out_last_q;
    assign blk_cnt_o  = blk_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_last_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else if (out_valid_q) begin
            if (out_ack_i) begin
                out_last_q <= 1'b0;
                blk_cnt_q  <= (state_q == PAD) ? 16'd0 : blk_cnt_q + 16'd1;
            end
        end else if (completes) begin
            out_last_q <= fin;
        end
    end
`endif

endmodule
